// File: rtl/sdram_arbiter.sv
// Shares the single-command SDRAM controller between video fetch, CPU byte access and loader writes.
// Owner is picked in IDLE, its strobe is held until the controller reports busy, and ack follows busy release.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic [19:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_we_n,
  output logic        mem_rdv,
  input  logic [15:0] mem_odata,
  input  logic        mem_cpubusy,
  input  logic        mem_vidbusy,
  output logic        err_timeout
);

  // state     | meaning
  // IDLE      | pick an owner, latch addr/data, raise its strobe
  // ISSUE     | strobe held until the owner's busy flag rises
  // WAIT_DONE | strobe released, waiting for busy to fall
  // GAP       | one idle cycle with ack high; lets the controller re-arm its edge detectors
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LDR} owner_t;

  localparam logic [9:0] TMO_LIM    = 10'(TIMEOUT_CYC);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  starve_q, starve_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rd_q, cpu_rd_d;
  logic        vid_ack_q, vid_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        ldr_ack_q, ldr_ack_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_we_n_q, mem_we_n_d;
  logic        mem_rdv_q, mem_rdv_d;

  logic        owner_busy;
  logic [9:0]  tmo_inc;
  logic        done;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_rd_d    = cpu_rd_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_we_n_d  = mem_we_n_q;
    mem_rdv_d   = mem_rdv_q;
    done        = 1'b0;
    owner_busy  = (owner_q == OWN_VID) ? mem_vidbusy : mem_cpubusy;
    tmo_inc     = tmo_q + 10'd1;

    case (state_q)
      S_IDLE: begin
        if (!ldr_req) starve_d = 3'd0;
        if (vid_req) begin
          owner_d    = OWN_VID;
          mem_addr_d = vid_addr;
          mem_rdv_d  = 1'b1;
          tmo_d      = 10'd0;
          state_d    = S_ISSUE;
        end else if (ldr_req && (starve_q == STARVE_LIM || !cpu_req)) begin
          owner_d     = OWN_LDR;
          mem_addr_d  = ldr_addr;
          mem_wdata_d = {8'h00, ldr_wdata};
          mem_we_n_d  = 1'b0;
          starve_d    = 3'd0;
          tmo_d       = 10'd0;
          state_d     = S_ISSUE;
        end else if (cpu_req) begin
          owner_d     = OWN_CPU;
          cpu_rd_d    = !cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = {8'h00, cpu_wdata};
          mem_rd_d    = !cpu_we;
          mem_we_n_d  = !cpu_we;
          tmo_d       = 10'd0;
          state_d     = S_ISSUE;
          if (ldr_req && starve_q != STARVE_LIM) starve_d = starve_q + 3'd1;
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_LIM) begin
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = S_GAP;
        end else if (owner_busy) begin
          state_d = S_WAIT_DONE;
        end
        if (state_d != S_ISSUE) begin
          mem_rd_d   = 1'b0;
          mem_we_n_d = 1'b1;
          mem_rdv_d  = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (!owner_busy) begin
          if (owner_q == OWN_VID) vid_rdata_d = mem_odata;
          if (owner_q == OWN_CPU && cpu_rd_q) cpu_rdata_d = mem_odata[7:0];
          done    = 1'b1;
          state_d = S_GAP;
        end else if (tmo_inc == TMO_LIM) begin
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ack is raised on the edge into GAP, so it is high for exactly that cycle.
    if (done) begin
      vid_ack_d = (owner_q == OWN_VID);
      cpu_ack_d = (owner_q == OWN_CPU);
      ldr_ack_d = (owner_q == OWN_LDR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_VID;
      starve_q    <= 3'd0;
      tmo_q       <= 10'd0;
      err_q       <= 1'b0;
      vid_rdata_q <= 16'h0000;
      cpu_rdata_q <= 8'h00;
      cpu_rd_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      mem_addr_q  <= 20'h00000;
      mem_wdata_q <= 16'h0000;
      mem_rd_q    <= 1'b0;
      mem_we_n_q  <= 1'b1;
      mem_rdv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_rd_q    <= cpu_rd_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_n_q  <= mem_we_n_d;
      mem_rdv_q   <= mem_rdv_d;
    end
  end

  assign vid_rdata   = vid_rdata_q;
  assign vid_ack     = vid_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign ldr_ack     = ldr_ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_we_n    = mem_we_n_q;
  assign mem_rdv     = mem_rdv_q;
  assign err_timeout = err_q;

endmodule
